// File: rtl/rom_reader_pkg.sv
// Shared constants for the ROM reader slice: FSM state encoding and default bus widths
// (the widths are also used by address_display).
package rom_reader_pkg;

  localparam int unsigned ROM_ADDR_WIDTH = 9;
  localparam int unsigned ROM_DATA_WIDTH = 8;
  localparam int unsigned STATE_WIDTH    = 3;

  typedef enum logic [STATE_WIDTH-1:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_ACCESS  = 3'd2,
    ST_HANDOFF = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/rom_read_sequencer_if.sv
// ROM bus plus the downstream valid/ready byte stream of the ROM read sequencer.
interface rom_read_sequencer_if
  import rom_reader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ROM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = ROM_DATA_WIDTH
);

  logic [ADDR_WIDTH-1:0] rom_addr;
  logic                  rom_ce_n;
  logic                  rom_oe_n;
  logic [DATA_WIDTH-1:0] rom_data;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output rom_addr, rom_ce_n, rom_oe_n, out_data, out_valid,
    input  rom_data, out_ready
  );

  modport slave (
    input  rom_addr, rom_ce_n, rom_oe_n, out_data, out_valid,
    output rom_data, out_ready
  );

endinterface

// File: rtl/rom_access_timer.sv
// Loadable down-counter timing the OE-asserted window; expired_c marks the last access cycle.
module rom_access_timer #(
  parameter int unsigned ACCESS_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expired_c
);

  localparam int unsigned CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CNT_W'(ACCESS_CYCLES - 1);
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_c = en && (cnt_q == '0);

endmodule

// File: rtl/rom_read_sequencer.sv
// Dumps a parallel ROM from address 0 to LAST_ADDR with a programmable access time and hands
// each byte downstream over valid/ready. Optional running checksum: ROM_READ_CHECKSUM_EN.
module rom_read_sequencer
  import rom_reader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = ROM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH    = ROM_DATA_WIDTH,
  parameter int unsigned LAST_ADDR     = 511,
  parameter int unsigned ACCESS_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  rom_read_sequencer_if.master  bus,
  output logic [ADDR_WIDTH-1:0] display_addr,
  output logic                  busy,
  output logic                  done
`ifdef ROM_READ_CHECKSUM_EN
  ,
  output logic [15:0]           checksum,
  output logic                  checksum_valid
`endif
);

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(LAST_ADDR);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic [ADDR_WIDTH-1:0] display_addr_q, display_addr_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  rom_ce_n_q, rom_ce_n_d;
  logic                  rom_oe_n_q, rom_oe_n_d;
  logic                  out_valid_q, out_valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  expired_c;
  logic                  hs_c;

  rom_access_timer #(.ACCESS_CYCLES(ACCESS_CYCLES)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (state_q == ST_SETUP),
    .en        (state_q == ST_ACCESS),
    .expired_c (expired_c)
  );

  assign hs_c = (state_q == ST_HANDOFF) && out_valid_q && bus.out_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // abort beats both the access timer and the handshake
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_SETUP;
      ST_SETUP:   state_d = abort ? ST_IDLE : ST_ACCESS;
      ST_ACCESS: begin
        if (abort)          state_d = ST_IDLE;
        else if (expired_c) state_d = ST_HANDOFF;
      end
      ST_HANDOFF: begin
        if (abort)     state_d = ST_IDLE;
        else if (hs_c) state_d = (rom_addr_q == LAST) ? ST_DONE : ST_SETUP;
      end
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Registered outputs follow the state being entered, so they line up with state_q
  always_comb begin
    rom_addr_d     = rom_addr_q;
    display_addr_d = display_addr_q;
    out_data_d     = out_data_q;
    if ((state_q == ST_IDLE) && start) begin
      rom_addr_d = '0;
    end
    if ((state_q == ST_ACCESS) && expired_c && !abort) begin
      out_data_d = bus.rom_data;
    end
    if (hs_c && !abort && (rom_addr_q < LAST)) begin
      rom_addr_d = rom_addr_q + ADDR_WIDTH'(1);
    end
    if (state_d == ST_HANDOFF) begin
      display_addr_d = rom_addr_q;
    end
    rom_ce_n_d  = !((state_d == ST_SETUP) || (state_d == ST_ACCESS));
    rom_oe_n_d  = (state_d != ST_ACCESS);
    out_valid_d = (state_d == ST_HANDOFF);
    busy_d      = (state_d == ST_SETUP) || (state_d == ST_ACCESS) || (state_d == ST_HANDOFF);
    done_d      = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rom_addr_q     <= '0;
      display_addr_q <= '0;
      out_data_q     <= '0;
      rom_ce_n_q     <= 1'b1;
      rom_oe_n_q     <= 1'b1;
      out_valid_q    <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      rom_addr_q     <= rom_addr_d;
      display_addr_q <= display_addr_d;
      out_data_q     <= out_data_d;
      rom_ce_n_q     <= rom_ce_n_d;
      rom_oe_n_q     <= rom_oe_n_d;
      out_valid_q    <= out_valid_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign bus.rom_addr  = rom_addr_q;
  assign bus.rom_ce_n  = rom_ce_n_q;
  assign bus.rom_oe_n  = rom_oe_n_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign display_addr  = display_addr_q;
  assign busy          = busy_q;
  assign done          = done_q;

`ifdef ROM_READ_CHECKSUM_EN
  logic [15:0] checksum_q, checksum_d;
  logic        checksum_valid_q, checksum_valid_d;

  // Every accepted byte counts, even one accepted alongside an abort
  always_comb begin
    checksum_d       = checksum_q;
    checksum_valid_d = checksum_valid_q;
    if ((state_q == ST_IDLE) && start) begin
      checksum_d       = '0;
      checksum_valid_d = 1'b0;
    end
    if (hs_c) begin
      checksum_d = checksum_q + 16'(out_data_q);
    end
    if (state_d == ST_DONE) begin
      checksum_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      checksum_q       <= '0;
      checksum_valid_q <= 1'b0;
    end else begin
      checksum_q       <= checksum_d;
      checksum_valid_q <= checksum_valid_d;
    end
  end

  assign checksum       = checksum_q;
  assign checksum_valid = checksum_valid_q;
`endif

endmodule

// File: tb/tb_rom_read_sequencer.sv
// Self-checking bench for rom_read_sequencer: directed scenarios plus randomized traffic
// checked every cycle against a cycle-position model of the dump.
module tb_rom_read_sequencer;
  import rom_reader_pkg::*;

  localparam int unsigned AW   = ROM_ADDR_WIDTH;
  localparam int unsigned DW   = ROM_DATA_WIDTH;
  localparam int unsigned LAST = 3;
  localparam int unsigned ACC  = 4;
  localparam int          HS   = ACC + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] display_addr;
  logic          busy;
  logic          done;
`ifdef ROM_READ_CHECKSUM_EN
  logic [15:0]   checksum;
  logic          checksum_valid;
`endif

  int checks = 0;
  int failures = 0;

  rom_read_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  rom_read_sequencer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LAST_ADDR(LAST), .ACCESS_CYCLES(ACC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .abort          (abort),
    .bus            (bus),
    .display_addr   (display_addr),
    .busy           (busy),
    .done           (done)
`ifdef ROM_READ_CHECKSUM_EN
    ,
    .checksum       (checksum),
    .checksum_valid (checksum_valid)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
    return a[DW-1:0] ^ 8'hA5;
  endfunction

  // ROM only drives real data while both strobes are asserted
  assign bus.rom_data = (!bus.rom_ce_n && !bus.rom_oe_n) ? rom_fn(bus.rom_addr) : 8'h3C;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: mode 0 idle, 1 dumping, 2 done; pos = cycles into the current byte
  int            m_mode = 0;
  int            m_pos = 0;
  logic [AW-1:0] m_addr = '0;
  logic [AW-1:0] m_disp = '0;
  logic [DW-1:0] m_data = '0;
  logic [15:0]   m_csum = '0;
  logic          m_csv = 1'b0;
  logic          m_known = 1'b0;
  logic          m_hs;

  always @(posedge clk) begin
    if (!reset) begin
      m_mode = 0; m_pos = 0; m_addr = '0; m_disp = '0; m_data = '0;
      m_csum = '0; m_csv = 1'b0; m_known = 1'b1;
    end else if (m_known) begin
      case (m_mode)
        0: if (start) begin
          m_mode = 1; m_pos = 0; m_addr = '0; m_csum = '0; m_csv = 1'b0;
        end
        2: m_mode = 0;
        default: begin
          m_hs = (m_pos == HS) && bus.out_ready;
          if (m_hs) m_csum = m_csum + 16'(m_data);
          if (abort) begin
            m_mode = 0; m_csv = 1'b0;
          end else if (m_pos < HS) begin
            if (m_pos == ACC) begin
              m_data = rom_fn(m_addr);
              m_disp = m_addr;
            end
            m_pos++;
          end else if (m_hs) begin
            if (m_addr == AW'(LAST)) begin
              m_mode = 2; m_csv = 1'b1;
            end else begin
              m_addr = m_addr + AW'(1);
              m_pos = 0;
            end
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      chk("rom_addr", 32'(bus.rom_addr), 32'(m_addr));
      chk("display_addr", 32'(display_addr), 32'(m_disp));
      chk("out_data", 32'(bus.out_data), 32'(m_data));
      chk("rom_ce_n", 32'(bus.rom_ce_n), 32'(!(m_mode == 1 && m_pos <= ACC)));
      chk("rom_oe_n", 32'(bus.rom_oe_n), 32'(!(m_mode == 1 && m_pos >= 1 && m_pos <= ACC)));
      chk("out_valid", 32'(bus.out_valid), 32'(m_mode == 1 && m_pos == HS));
      chk("busy", 32'(busy), 32'(m_mode == 1));
      chk("done", 32'(done), 32'(m_mode == 2));
`ifdef ROM_READ_CHECKSUM_EN
      chk("checksum", 32'(checksum), 32'(m_csum));
      chk("checksum_valid", 32'(checksum_valid), 32'(m_csv));
`endif
    end
  end

  task automatic wait_valid(input string nm);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  initial begin
    int            vcyc[$];
    logic [DW-1:0] vdat[$];
    logic [DW-1:0] exp_d[4];
    logic [AW-1:0] seen[$];
    int            dcyc;
    int            ndone;
    logic          stable;
    logic          bad;
    logic          ok;
`ifdef ROM_READ_CHECKSUM_EN
    logic [15:0]   csum_at_done;
    logic          csv_at_done;
    csum_at_done = '0;
    csv_at_done = 1'b0;
`endif
    exp_d = '{8'hA5, 8'hA4, 8'hA7, 8'hA6};
    bus.out_ready = 1'b0;
    dcyc = 0;
    ndone = 0;

    // reset values
    repeat (2) tick();
    chk("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
    chk("rst_ce_n", 32'(bus.rom_ce_n), 32'd1);
    chk("rst_oe_n", 32'(bus.rom_oe_n), 32'd1);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // full dump with ready tied high; byte timing pinned by literals
    reset = 1'b1;
    tick();
    bus.out_ready = 1'b1;
    start = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      start = 1'b0;
      if (bus.out_valid === 1'b1) begin
        vcyc.push_back(c);
        vdat.push_back(bus.out_data);
      end
      if (done === 1'b1) begin
        dcyc = c;
        ndone++;
`ifdef ROM_READ_CHECKSUM_EN
        csum_at_done = checksum;
        csv_at_done = checksum_valid;
`endif
      end
    end
    chk("t1_nbytes", 32'(vcyc.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < vcyc.size()) begin
        chk("t1_byte_cycle", 32'(vcyc[i]), 32'(6 * (i + 1)));
        chk("t1_byte_data", 32'(vdat[i]), 32'(exp_d[i]));
      end
    end
    chk("t1_done_cycle", 32'(dcyc), 32'd25);
    chk("t1_done_count", 32'(ndone), 32'd1);
    chk("t1_busy_after", 32'(busy), 32'd0);
`ifdef ROM_READ_CHECKSUM_EN
    chk("t1_checksum", 32'(csum_at_done), 32'h0296);
    chk("t1_checksum_valid", 32'(csv_at_done), 32'd1);
`endif

    // consumer stalls 20 cycles on address 2
    bus.out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int b = 0; b <= int'(LAST); b++) begin
      wait_valid("t2_valid_timeout");
      if (b == 2) begin
        stable = 1'b1;
        repeat (20) begin
          tick();
          if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA7 ||
              bus.rom_ce_n !== 1'b1 || bus.rom_oe_n !== 1'b1) stable = 1'b0;
        end
        chk("t2_hold_stable", 32'(stable), 32'd1);
        chk("t2_hold_addr", 32'(bus.rom_addr), 32'd2);
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      if (b == 2) chk("t2_addr_after_hs", 32'(bus.rom_addr), 32'd3);
    end
    repeat (3) tick();

    // abort during ACCESS of address 1, then restart from 0
    bus.out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.rom_addr == AW'(1) && bus.rom_oe_n === 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("t3_reach_access", 32'(ok), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t3_busy", 32'(busy), 32'd0);
    chk("t3_ce_n", 32'(bus.rom_ce_n), 32'd1);
    chk("t3_oe_n", 32'(bus.rom_oe_n), 32'd1);
    chk("t3_addr_held", 32'(bus.rom_addr), 32'd1);
    bad = 1'b0;
    repeat (10) begin
      tick();
      if (done !== 1'b0 || bus.out_valid !== 1'b0) bad = 1'b1;
    end
    chk("t3_quiet_after_abort", 32'(bad), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t3_restart_addr", 32'(bus.rom_addr), 32'd0);
    wait_valid("t3_valid_timeout");
    chk("t3_restart_byte", 32'(bus.out_data), 32'hA5);
    repeat (30) tick();

    // reset while presenting a byte
    bus.out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid("t4_valid_timeout");
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("t4_rom_addr", 32'(bus.rom_addr), 32'd0);
    chk("t4_display", 32'(display_addr), 32'd0);
    chk("t4_out_data", 32'(bus.out_data), 32'd0);
    chk("t4_valid", 32'(bus.out_valid), 32'd0);
    chk("t4_strobes", 32'({bus.rom_ce_n, bus.rom_oe_n}), 32'd3);
    chk("t4_busy_done", 32'({busy, done}), 32'd0);

    // start toggled while busy must not disturb the address sequence
    bus.out_ready = 1'b1;
    start = 1'b1;
    tick();
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bus.out_valid === 1'b1) seen.push_back(display_addr);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      start = 1'($urandom_range(0, 1));
      tick();
    end
    start = 1'b0;
    chk("t5_done_seen", 32'(ok), 32'd1);
    chk("t5_nbytes", 32'(seen.size()), 32'(LAST + 1));
    for (int i = 0; i < seen.size(); i++) chk("t5_addr_seq", 32'(seen[i]), 32'(i));
    repeat (3) tick();

    // randomized traffic checked by the model every cycle
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 299) != 0);
      start = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 59) == 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
